logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the team's two-input gate-level logic block.
- Applies one of eight bitwise operations to two WIDTH-bit operands, selected per transaction by an opcode.
- Results leave through a 2-stage valid/ready pipeline together with zero and parity flags.
- Sits between an operand source and a result consumer; either side may stall independently.

Parameters:
- WIDTH, 8, operand and result width in bits (1 to 64).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand transaction present
- in_ready  output  1  unit accepts the operand transaction this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  operation select
- out_valid  output  1  result transaction present
- out_ready  input  1  consumer accepts the result this cycle
- y  output  WIDTH  result
- zero  output  1  1 when y == 0
- parity  output  1  XOR-reduction of y
- busy  output  1  1 when any pipeline stage holds a transaction

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous and active-high; it is sampled only on the rising edge of clk.
- Opcodes (all bitwise across WIDTH):
  - 0: AND
  - 1: OR
  - 2: XOR
  - 3: NAND
  - 4: NOR
  - 5: XNOR
  - 6: NOT a (b ignored)
  - 7: a AND NOT b
- Input transfer: occurs when in_valid && in_ready on a rising edge. Output transfer: occurs when out_valid && out_ready.
- Stage 1 register (s1_valid, s1_y): loads the opcode result on input transfer.
- Stage 2 register (s2_valid, y, zero, parity): loads s1_y plus its flags whenever stage 1 advances.
  - zero and parity are computed from s1_y at the load, not from y combinationally afterwards.
- Advance conditions:
  - s2_free = !s2_valid || out_ready
  - s1_advance = s1_valid && s2_free
  - in_ready = !rst && (!s1_valid || s2_free)
- Stage 1 next state:
  - On input transfer, s1_valid <= 1.
  - Otherwise, if s1_advance, s1_valid <= 0.
- Stage 2 next state:
  - If s1_advance, s2_valid <= 1.
  - Otherwise, if out_ready, s2_valid <= 0.
- Latency: 2 cycles from input transfer to out_valid when there is no stall. Throughput: 1 transaction per cycle with out_ready held high.
- Backpressure:
  - With out_ready low, up to 2 transactions are held. in_ready then drops.
  - While out_valid && !out_ready, y, zero and parity are stable.
  - No transaction is dropped or duplicated.
- Simultaneous events: output transfer, stage advance and input transfer may all occur in the same cycle; all three take effect and ordering is preserved.
- Operand or op changes while in_valid is low are ignored. Values are captured only on transfer.
- busy = s1_valid || s2_valid.
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, y=0, zero=0, parity=0, busy=0. in_ready=0 while rst is high.
- Reset mid-operation: all in-flight transactions are discarded. No out_valid appears for them after rst deasserts. in_ready is 1 on the first cycle after rst deasserts.
- WIDTH=1: zero = ~y and parity = y.
- Undefined op values cannot occur (3-bit field, fully decoded).

Test Plan:
- Opcode sweep, WIDTH=8, a=8'hC5, b=8'h3A, op=0..7 back-to-back, out_ready=1 -> y sequence 00,FF,FF,FF,00,00,3A,C5. zero=1 on the 1st, 5th and 6th results; parity matches the XOR-reduction of each y. Each result appears 2 cycles after its transfer.
- Backpressure: hold out_ready=0 and offer 3 transactions -> in_ready drops after 2 are accepted. y holds the first result unchanged. Releasing out_ready delivers all 3 in order with no gaps.
- Simultaneous events: with the pipe full, assert out_ready and in_valid in the same cycle -> one output transfer and one input transfer occur; busy stays 1; count in equals count out.
- Reset mid-flight: 2 transactions in the pipe, pulse rst for 1 cycle -> out_valid=0, y=0, zero=0, busy=0. No stale result is emitted. in_ready=1 the following cycle.
- WIDTH=1 instance, a=1, b=1, op=2 -> y=0, zero=1, parity=0. op=6 -> y=0.
- Random stall stress: random in_valid and out_ready, 1000 transactions, WIDTH=32 -> the output stream equals a reference model, in order.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit.
// Eight opcodes; result leaves with zero and parity flags.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic             busy
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_y;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_zero;
  logic             r_parity;

  logic [7:0]       w_sel;
  logic [WIDTH-1:0] w_res;
  logic             w_s2_free;
  logic             w_s1_adv;
  logic             w_in_fire;

  assign w_sel = 8'd1 << op;

  always_comb begin
    w_res = '0;
    unique case (1'b1)
      w_sel[0]: w_res = a & b;
      w_sel[1]: w_res = a | b;
      w_sel[2]: w_res = a ^ b;
      w_sel[3]: w_res = ~(a & b);
      w_sel[4]: w_res = ~(a | b);
      w_sel[5]: w_res = ~(a ^ b);
      w_sel[6]: w_res = ~a;
      w_sel[7]: w_res = a & ~b;
      default:  w_res = '0;
    endcase
  end

  assign w_s2_free = !r_s2_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_free;
  assign in_ready  = !rst && (!r_s1_valid || w_s2_free);
  assign w_in_fire = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_y     <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_y     <= w_res;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Flags are computed from the stage-1 value at load time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_y        <= '0;
      r_zero     <= 1'b0;
      r_parity   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_y        <= r_s1_y;
      r_zero     <= ~|r_s1_y;
      r_parity   <= ^r_s1_y;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign out_valid = r_s2_valid;
  assign y         = r_y;
  assign zero      = r_zero;
  assign parity    = r_parity;
  assign busy      = r_s1_valid || r_s2_valid;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe at WIDTH 8, 1 and 32.
// WIDTH=32 adds a random-stall stream against a queue model.
module tb_logic_unit_pipe;

  logic clk;
  logic rst;

  logic       iv8, ir8, ov8, or8, z8, p8, bz8;
  logic [7:0] a8, b8, y8;
  logic [2:0] op8;

  logic       iv1, ir1, ov1, z1, p1, bz1;
  logic [0:0] a1, b1, y1;
  logic [2:0] op1;

  logic        iv32, ir32, ov32, or32, z32, p32, bz32;
  logic [31:0] a32, b32, y32;
  logic [2:0]  op32;

  int n_total;
  int n_bad;
  int cnt_in;
  int cnt_out;
  int n_sent;
  int n_recv;
  logic acc32;
  logic [31:0] q32[$];

  logic_unit_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .op(op8),
    .out_valid(ov8), .out_ready(or8),
    .y(y8), .zero(z8), .parity(p8), .busy(bz8)
  );

  logic_unit_pipe #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .op(op1),
    .out_valid(ov1), .out_ready(1'b1),
    .y(y1), .zero(z1), .parity(p1), .busy(bz1)
  );

  logic_unit_pipe #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .op(op32),
    .out_valid(ov32), .out_ready(or32),
    .y(y32), .zero(z32), .parity(p32), .busy(bz32)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref32(input logic [2:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] z);
    case (o)
      3'd0: ref32 = x & z;
      3'd1: ref32 = x | z;
      3'd2: ref32 = x ^ z;
      3'd3: ref32 = ~(x & z);
      3'd4: ref32 = ~(x | z);
      3'd5: ref32 = ~(x ^ z);
      3'd6: ref32 = ~x;
      default: ref32 = x & ~z;
    endcase
  endfunction

  // Transfers are sampled mid-cycle, between input drive and the next edge.
  always @(negedge clk) begin
    logic [31:0] e;
    acc32 = iv32 && ir32;
    if (!rst) begin
      if (iv8 && ir8) cnt_in++;
      if (ov8 && or8) cnt_out++;
      if (iv32 && ir32) begin
        q32.push_back(ref32(op32, a32, b32));
        n_sent++;
      end
      if (ov32 && or32) begin
        if (q32.size() == 0) begin
          chk("w32_extra", 1, 0);
        end else begin
          e = q32.pop_front();
          chk("w32_y", y32, e);
          chk("w32_zero", z32, e == 0);
          chk("w32_par", p32, ^e);
        end
        n_recv++;
      end
    end
  end

  task automatic put8(input logic [7:0] x, input logic [7:0] z,
                      input logic [2:0] o);
    iv8 = 1'b1;
    a8  = x;
    b8  = z;
    op8 = o;
  endtask

  logic [7:0] sw_y [8] = '{8'h00, 8'hFF, 8'hFF, 8'hFF,
                           8'h00, 8'h00, 8'h3A, 8'hC5};
  logic       sw_z [8] = '{1'b1, 1'b0, 1'b0, 1'b0,
                           1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int ci, co;
    n_total = 0; n_bad = 0;
    cnt_in = 0; cnt_out = 0;
    n_sent = 0; n_recv = 0;
    acc32 = 1'b0;
    clk = 1'b0; rst = 1'b1;
    iv8 = 0; a8 = 0; b8 = 0; op8 = 0; or8 = 1;
    iv1 = 0; a1 = 0; b1 = 0; op1 = 0;
    iv32 = 0; a32 = 0; b32 = 0; op32 = 0; or32 = 1;
    step();
    step();

    // reset state
    chk("rst_ov", ov8, 0);
    chk("rst_busy", bz8, 0);
    chk("rst_y", y8, 0);
    chk("rst_zero", z8, 0);
    chk("rst_par", p8, 0);
    chk("rst_ir", ir8, 0);
    rst = 1'b0;
    #1;
    chk("rst_ir_rel", ir8, 1);

    // opcode sweep, two-cycle latency
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        put8(8'hC5, 8'h3A, 3'(c));
        chk("sw_ir", ir8, 1);
      end else begin
        iv8 = 1'b0;
      end
      if (c >= 2) begin
        chk("sw_ov", ov8, 1);
        chk("sw_y", y8, sw_y[c-2]);
        chk("sw_zero", z8, sw_z[c-2]);
        chk("sw_par", p8, 0);
      end else begin
        chk("sw_lat", ov8, 0);
      end
      step();
    end
    put8(8'h0B, 8'h00, 3'd2);
    step();
    iv8 = 1'b0;
    step();
    chk("par1_y", y8, 8'h0B);
    chk("par1_p", p8, 1);
    chk("par1_z", z8, 0);
    step();
    chk("drain_busy", bz8, 0);

    // backpressure: three offered, two held
    or8 = 1'b0;
    put8(8'hF0, 8'h0F, 3'd1);
    chk("bp_ir0", ir8, 1);
    step();
    put8(8'hF0, 8'hFF, 3'd0);
    chk("bp_ir1", ir8, 1);
    step();
    put8(8'hA5, 8'h0F, 3'd7);
    chk("bp_ir_drop", ir8, 0);
    chk("bp_ov", ov8, 1);
    chk("bp_y0", y8, 8'hFF);
    step();
    step();
    chk("bp_hold_y", y8, 8'hFF);
    chk("bp_hold_ir", ir8, 0);
    or8 = 1'b1;
    #1;
    chk("bp_ir_up", ir8, 1);
    step();
    iv8 = 1'b0;
    chk("bp_ov1", ov8, 1);
    chk("bp_y1", y8, 8'hF0);
    step();
    chk("bp_ov2", ov8, 1);
    chk("bp_y2", y8, 8'hA0);
    step();
    chk("bp_end_ov", ov8, 0);
    chk("bp_end_busy", bz8, 0);

    // simultaneous output, advance and input
    ci = cnt_in;
    co = cnt_out;
    or8 = 1'b0;
    put8(8'h12, 8'h34, 3'd1);
    step();
    put8(8'h0F, 8'hFF, 3'd2);
    step();
    put8(8'hFF, 8'h00, 3'd4);
    or8 = 1'b1;
    step();
    iv8 = 1'b0;
    chk("sim_busy", bz8, 1);
    chk("sim_in", cnt_in - ci, 3);
    chk("sim_out", cnt_out - co, 1);
    chk("sim_y", y8, 8'hF0);
    step();
    chk("sim_y2", y8, 8'h00);
    chk("sim_z2", z8, 1);
    step();
    chk("sim_busy_end", bz8, 0);
    chk("sim_balance", cnt_in - ci, cnt_out - co);

    // reset mid-flight
    or8 = 1'b0;
    put8(8'h55, 8'h00, 3'd1);
    step();
    put8(8'h66, 8'h00, 3'd1);
    step();
    iv8 = 1'b0;
    rst = 1'b1;
    #1;
    chk("mr_ir_rst", ir8, 0);
    step();
    rst = 1'b0;
    or8 = 1'b1;
    #1;
    chk("mr_ov", ov8, 0);
    chk("mr_y", y8, 0);
    chk("mr_zero", z8, 0);
    chk("mr_busy", bz8, 0);
    chk("mr_ir", ir8, 1);
    ci = cnt_out;
    repeat (4) step();
    chk("mr_stale", cnt_out - ci, 0);

    // WIDTH=1 instance
    iv1 = 1; a1 = 1'b1; b1 = 1'b1; op1 = 3'd2;
    step();
    op1 = 3'd6;
    step();
    a1 = 1'b0; op1 = 3'd1;
    chk("w1_xor_y", y1, 0);
    chk("w1_xor_z", z1, 1);
    chk("w1_xor_p", p1, 0);
    step();
    iv1 = 0;
    chk("w1_not_y", y1, 0);
    step();
    chk("w1_or_y", y1, 1);
    chk("w1_or_z", z1, 0);
    chk("w1_or_p", p1, 1);

    // WIDTH=32 random stall stream
    for (int c = 0; c < 20000 && n_sent < 1000; c++) begin
      or32 = ($urandom_range(0, 3) != 0);
      if (!iv32 || acc32) begin
        iv32 = ($urandom_range(0, 1) == 1);
        a32  = $urandom;
        b32  = $urandom;
        op32 = 3'($urandom_range(0, 7));
      end
      step();
    end
    iv32 = 1'b0;
    or32 = 1'b1;
    for (int c = 0; c < 50 && n_recv < n_sent; c++) step();
    chk("w32_sent", n_sent, 1000);
    chk("w32_recv", n_recv, 1000);
    chk("w32_qempty", q32.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
